mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the execute-to-memory bus and consumes the synchronous data-SRAM read data.
- Performs load byte/halfword selection and extension, and selects the register-file write data.
- Squashes writebacks on exceptions, then drives the writeback bus, the forwarding bus to decode, and the exception report to CP0.
- Holds load data across stalls so that a returned SRAM word is never lost.

Parameters:
- STALL_WD, 6, width of the pipeline stall vector.
- EX_TO_MEM_WD, 166, width of the incoming bus.
- MEM_TO_WB_WD, 136, width of the writeback bus.
- MEM_TO_RF_WD, 104, width of the forwarding bus.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  exception/ERET flush; kills the instruction being captured.
- stall  in  STALL_WD  stall vector; bit 3 = EX held, bit 4 = MEM held.
- ex_to_mem_bus  in  166  fields, MSB to LSB:
  - excepttype[165:151]
  - mem_op[150:143] = {lb,lbu,lh,lhu,lw,sb,sh,sw}
  - hilo[142:77] = {hi_we,hi[31:0],lo_we,lo[31:0]}
  - pc[76:45], ram_en[44], ram_wen[43], ram_sel[42:39]
  - sel_rf_res[38], rf_we[37], rf_waddr[36:32], result[31:0]
- data_sram_rdata  in  32  SRAM read data; valid in the first cycle the load occupies MEM.
- mem_to_wb_bus  out  136  {hilo[65:0], pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- mem_to_rf_bus  out  104  {hilo[65:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}; forwarding to decode.
- except_valid  out  1  any cause bit set in the registered excepttype.
- mem_excepttype  out  15  registered excepttype.
- mem_pc  out  32  registered pc.
- mem_bad_vaddr  out  32  registered result (the address), used for AdEL/AdES.

Behaviour:
- Pipeline register bus_r update, in priority order:
  - rst: 0.
  - flush: 0.
  - stall[3]=1 and stall[4]=0: 0 (bubble).
  - stall[3]=0: capture ex_to_mem_bus.
  - otherwise: hold.
- first flag:
  - 0 on rst/flush/bubble.
  - 1 in the cycle after a capture.
  - Cleared after one cycle of hold.
- hold_rdata register:
  - 0 on rst.
  - Loads data_sram_rdata when first=1.
- Load word source: rdata_eff = first ? data_sram_rdata : hold_rdata.
  - Correct regardless of how long stall[4] is held.
- Load extension, with b = byte at ram_sel and h = half at ram_sel:
  - Byte position: sel 0001 → [7:0], 0010 → [15:8], 0100 → [23:16], 1000 → [31:24].
  - Halfword position: sel 0011 → [15:0], 1100 → [31:16].
  - lb: sign-extend b. lbu: zero-extend b.
  - lh: sign-extend h. lhu: zero-extend h.
  - lw: rdata_eff.
  - Exactly one of the load ops, or none, is asserted.
- rf_wdata = sel_rf_res ? load_data : result.
- Exception squash: when except_valid=1, rf_we, hi_we and lo_we are forced to 0 on both output buses; all other fields pass through.
- except_valid = |excepttype. It is combinational from bus_r with no extra cycle.
- Latency: one register stage; all outputs are combinational from bus_r, first and hold_rdata.
- Reset values: every output is 0, since bus_r=0 and hold_rdata=0.
- Bubble cycles: identical to reset, with no write enables.
- Simultaneous flush and stall: flush wins.
- Reset mid-stall: the register clears on the next edge and hold_rdata is discarded.
- Stores: no rdata is used; rf_we=0 as decoded upstream.

Test Plan:
- lb, result=0x1001, sel=0010, rdata=0x12A4_5678, rf_waddr=5 → rf_wdata=0x0000_0056, rf_we=1, waddr=5. With rdata=0x1234_8078, sel=0010 → 0xFFFF_FF80.
- lhu, sel=1100, rdata=0xBEEF_0001 → 0x0000_BEEF. lh with the same inputs → 0xFFFF_BEEF.
- lw captured with rdata=0xCAFE_F00D, then stall[4]=1 for 3 cycles while rdata changes to 0x0 → rf_wdata stays 0xCAFE_F00D every cycle.
- stall[3]=1, stall[4]=0 → next cycle both buses are all-zero, except_valid=0. flush=1 and stall[3]=0 with a valid bus → next cycle bus_r=0.
- Incoming excepttype bit 7 (AdEL) set, rf_we=1, hi_we=1 → except_valid=1, rf_we=0 and hi_we=0 on both buses, mem_bad_vaddr = result.
- Non-load ALU op, result=0x1234_5678, rf_we=1, waddr=31 → mem_to_rf_bus rf_wdata=0x1234_5678 in the same cycle as mem_to_wb_bus. rst asserted → all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Signal bundle between the execute stage, the MEM stage, the data SRAM and the downstream consumers.
// The MEM stage attaches through the slave modport; the upstream/test side uses master.
interface mem_stage_if #(
  parameter int STALL_WD     = 6,
  parameter int EX_TO_MEM_WD = 166,
  parameter int MEM_TO_WB_WD = 136,
  parameter int MEM_TO_RF_WD = 104
) ();
  logic                    flush;
  logic [STALL_WD-1:0]     stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;
  logic                    except_valid;
  logic [14:0]             mem_excepttype;
  logic [31:0]             mem_pc;
  logic [31:0]             mem_bad_vaddr;

  modport master (
    output flush, stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_rf_bus, except_valid, mem_excepttype, mem_pc, mem_bad_vaddr
  );

  modport slave (
    input  flush, stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_rf_bus, except_valid, mem_excepttype, mem_pc, mem_bad_vaddr
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the execute bus, extends load data from the synchronous SRAM,
// squashes writes on exceptions and drives the writeback, forwarding and CP0 exception outputs.
module mem_stage #(
  parameter int STALL_WD     = 6,
  parameter int EX_TO_MEM_WD = 166,
  parameter int MEM_TO_WB_WD = 136,
  parameter int MEM_TO_RF_WD = 104
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic                    first;
  logic [31:0]             hold_rdata;

  // SRAM data is only present in the first MEM cycle; hold_rdata keeps it alive across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r      <= '0;
      first      <= 1'b0;
      hold_rdata <= '0;
    end else begin
      if (first) hold_rdata <= bus.data_sram_rdata;
      if (bus.flush || (bus.stall[3] && !bus.stall[4])) begin
        bus_r <= '0;
        first <= 1'b0;
      end else if (!bus.stall[3]) begin
        bus_r <= bus.ex_to_mem_bus;
        first <= 1'b1;
      end else begin
        first <= 1'b0;
      end
    end
  end

  logic [14:0] excepttype;
  logic        op_lb, op_lbu, op_lh, op_lhu, op_lw;
  logic        hi_we, lo_we;
  logic [31:0] hi, lo, pc, result;
  logic [3:0]  ram_sel;
  logic        sel_rf_res, rf_we;
  logic [4:0]  rf_waddr;

  assign excepttype = bus_r[165:151];
  assign op_lb      = bus_r[150];
  assign op_lbu     = bus_r[149];
  assign op_lh      = bus_r[148];
  assign op_lhu     = bus_r[147];
  assign op_lw      = bus_r[146];
  assign hi_we      = bus_r[142];
  assign hi         = bus_r[141:110];
  assign lo_we      = bus_r[109];
  assign lo         = bus_r[108:77];
  assign pc         = bus_r[76:45];
  assign ram_sel    = bus_r[42:39];
  assign sel_rf_res = bus_r[38];
  assign rf_we      = bus_r[37];
  assign rf_waddr   = bus_r[36:32];
  assign result     = bus_r[31:0];

  logic [31:0] rdata_eff;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] load_data;

  assign rdata_eff = first ? bus.data_sram_rdata : hold_rdata;

  always_comb begin
    b = 8'h00;
    case (ram_sel)
      4'b0001: b = rdata_eff[7:0];
      4'b0010: b = rdata_eff[15:8];
      4'b0100: b = rdata_eff[23:16];
      4'b1000: b = rdata_eff[31:24];
      default: b = 8'h00;
    endcase
  end

  always_comb begin
    h = 16'h0000;
    case (ram_sel)
      4'b0011: h = rdata_eff[15:0];
      4'b1100: h = rdata_eff[31:16];
      default: h = 16'h0000;
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    if (op_lb)       load_data = {{24{b[7]}}, b};
    else if (op_lbu) load_data = {24'h0, b};
    else if (op_lh)  load_data = {{16{h[15]}}, h};
    else if (op_lhu) load_data = {16'h0, h};
    else if (op_lw)  load_data = rdata_eff;
  end

  logic        exc;
  logic        rf_we_o, hi_we_o, lo_we_o;
  logic [31:0] rf_wdata;
  logic [65:0] hilo_o;

  // A faulting instruction must not write any architectural register.
  assign exc      = |excepttype;
  assign rf_we_o  = rf_we & ~exc;
  assign hi_we_o  = hi_we & ~exc;
  assign lo_we_o  = lo_we & ~exc;
  assign rf_wdata = sel_rf_res ? load_data : result;
  assign hilo_o   = {hi_we_o, hi, lo_we_o, lo};

  assign bus.mem_to_wb_bus  = {hilo_o, pc, rf_we_o, rf_waddr, rf_wdata};
  assign bus.mem_to_rf_bus  = {hilo_o, rf_we_o, rf_waddr, rf_wdata};
  assign bus.except_valid   = exc;
  assign bus.mem_excepttype = excepttype;
  assign bus.mem_pc         = pc;
  assign bus.mem_bad_vaddr  = result;

  // Store ops, SRAM enables and the other stall bits are consumed elsewhere in the pipeline.
  logic unused_bits;
  assign unused_bits = ^{bus_r[145:143], bus_r[44:43], bus.stall};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extension, stall hold, bubble, flush, exception squash, reset.
module tb_mem_stage;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_stage_if #(.STALL_WD(6), .EX_TO_MEM_WD(166), .MEM_TO_WB_WD(136), .MEM_TO_RF_WD(104)) bus_if ();

  mem_stage #(.STALL_WD(6), .EX_TO_MEM_WD(166), .MEM_TO_WB_WD(136), .MEM_TO_RF_WD(104)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] OP_LB  = 8'b1000_0000;
  localparam logic [7:0] OP_LBU = 8'b0100_0000;
  localparam logic [7:0] OP_LH  = 8'b0010_0000;
  localparam logic [7:0] OP_LHU = 8'b0001_0000;
  localparam logic [7:0] OP_LW  = 8'b0000_1000;

  function automatic logic [165:0] mk_bus(
    input logic [14:0] exc, input logic [7:0] op,
    input logic hwe, input logic [31:0] hi, input logic lwe, input logic [31:0] lo,
    input logic [31:0] pc, input logic [3:0] sel, input logic srr, input logic we,
    input logic [4:0] waddr, input logic [31:0] result);
    logic ram_en;
    ram_en = (op != 8'h00);
    return {exc, op, hwe, hi, lwe, lo, pc, ram_en, 1'b0, sel, srr, we, waddr, result};
  endfunction

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb"}, 136'(bus_if.mem_to_wb_bus), 136'h0);
    chk({tag, "_rf"}, 136'(bus_if.mem_to_rf_bus), 136'h0);
    chk({tag, "_exc"}, 136'({bus_if.except_valid, bus_if.mem_excepttype}), 136'h0);
    chk({tag, "_pc"}, 136'({bus_if.mem_pc, bus_if.mem_bad_vaddr}), 136'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.flush           = 1'b0;
    bus_if.stall           = 6'b0;
    bus_if.ex_to_mem_bus   = '0;
    bus_if.data_sram_rdata = 32'h0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // lb, byte 1 positive
    bus_if.ex_to_mem_bus = mk_bus(15'h0, OP_LB, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 4'b0010, 1'b1, 1'b1, 5'd5, 32'h1001);
    tick();
    bus_if.data_sram_rdata = 32'h12A4_5678;
    #1;
    chk("lb_pos_rf", 136'(bus_if.mem_to_rf_bus), 136'({66'h0, 1'b1, 5'd5, 32'h0000_0056}));
    chk("lb_pos_wb", 136'(bus_if.mem_to_wb_bus), {66'h0, 32'h100, 1'b1, 5'd5, 32'h0000_0056});

    // lb, byte 1 negative
    bus_if.ex_to_mem_bus = mk_bus(15'h0, OP_LB, 1'b0, 32'h0, 1'b0, 32'h0, 32'h104, 4'b0010, 1'b1, 1'b1, 5'd5, 32'h1001);
    tick();
    bus_if.data_sram_rdata = 32'h1234_8078;
    #1;
    chk("lb_neg_rf", 136'(bus_if.mem_to_rf_bus), 136'({66'h0, 1'b1, 5'd5, 32'hFFFF_FF80}));

    // lbu, byte 3
    bus_if.ex_to_mem_bus = mk_bus(15'h0, OP_LBU, 1'b0, 32'h0, 1'b0, 32'h0, 32'h108, 4'b1000, 1'b1, 1'b1, 5'd6, 32'h1003);
    tick();
    bus_if.data_sram_rdata = 32'h9A00_0000;
    #1;
    chk("lbu_rf", 136'(bus_if.mem_to_rf_bus), 136'({66'h0, 1'b1, 5'd6, 32'h0000_009A}));

    // lhu upper half
    bus_if.ex_to_mem_bus = mk_bus(15'h0, OP_LHU, 1'b0, 32'h0, 1'b0, 32'h0, 32'h10C, 4'b1100, 1'b1, 1'b1, 5'd7, 32'h1002);
    tick();
    bus_if.data_sram_rdata = 32'hBEEF_0001;
    #1;
    chk("lhu_rf", 136'(bus_if.mem_to_rf_bus), 136'({66'h0, 1'b1, 5'd7, 32'h0000_BEEF}));

    // lh upper half
    bus_if.ex_to_mem_bus = mk_bus(15'h0, OP_LH, 1'b0, 32'h0, 1'b0, 32'h0, 32'h110, 4'b1100, 1'b1, 1'b1, 5'd7, 32'h1002);
    tick();
    bus_if.data_sram_rdata = 32'hBEEF_0001;
    #1;
    chk("lh_rf", 136'(bus_if.mem_to_rf_bus), 136'({66'h0, 1'b1, 5'd7, 32'hFFFF_BEEF}));

    // lh lower half, negative
    bus_if.ex_to_mem_bus = mk_bus(15'h0, OP_LH, 1'b0, 32'h0, 1'b0, 32'h0, 32'h114, 4'b0011, 1'b1, 1'b1, 5'd8, 32'h1000);
    tick();
    bus_if.data_sram_rdata = 32'h0001_8001;
    #1;
    chk("lh_lo_rf", 136'(bus_if.mem_to_rf_bus), 136'({66'h0, 1'b1, 5'd8, 32'hFFFF_8001}));

    // lw, then MEM held for three cycles while SRAM data goes away
    bus_if.ex_to_mem_bus = mk_bus(15'h0, OP_LW, 1'b0, 32'h0, 1'b0, 32'h0, 32'h118, 4'b1111, 1'b1, 1'b1, 5'd10, 32'h2000);
    tick();
    bus_if.data_sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("lw_first", 136'(bus_if.mem_to_wb_bus), {66'h0, 32'h118, 1'b1, 5'd10, 32'hCAFE_F00D});
    bus_if.stall = 6'b011000;
    bus_if.ex_to_mem_bus = mk_bus(15'h0, 8'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h11C, 4'b0, 1'b0, 1'b1, 5'd3, 32'h7777);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus_if.data_sram_rdata = 32'h0;
      #1;
      chk("lw_stall", 136'(bus_if.mem_to_wb_bus), {66'h0, 32'h118, 1'b1, 5'd10, 32'hCAFE_F00D});
    end

    // bubble: EX held, MEM free
    bus_if.stall = 6'b001000;
    tick();
    chk_all_zero("bubble");

    // flush beats a capture
    bus_if.stall = 6'b0;
    bus_if.flush = 1'b1;
    tick();
    chk_all_zero("flush");
    bus_if.flush = 1'b0;

    // AdEL exception squashes rf/hi/lo writes
    bus_if.ex_to_mem_bus = mk_bus(15'h0080, OP_LW, 1'b1, 32'h1111_2222, 1'b1, 32'h3333_4444, 32'h200, 4'b1111, 1'b0, 1'b1, 5'd9, 32'h2003);
    tick();
    bus_if.data_sram_rdata = 32'h5555_5555;
    #1;
    chk("exc_wb", 136'(bus_if.mem_to_wb_bus), {1'b0, 32'h1111_2222, 1'b0, 32'h3333_4444, 32'h200, 1'b0, 5'd9, 32'h2003});
    chk("exc_rf", 136'(bus_if.mem_to_rf_bus), 136'({1'b0, 32'h1111_2222, 1'b0, 32'h3333_4444, 1'b0, 5'd9, 32'h2003}));
    chk("exc_cp0", 136'({bus_if.except_valid, bus_if.mem_excepttype}), 136'({1'b1, 15'h0080}));
    chk("exc_addr", 136'({bus_if.mem_pc, bus_if.mem_bad_vaddr}), 136'({32'h200, 32'h2003}));

    // ALU result with hi write passes straight through
    bus_if.ex_to_mem_bus = mk_bus(15'h0, 8'h0, 1'b1, 32'hAAAA_0000, 1'b0, 32'h0000_0005, 32'h300, 4'b0, 1'b0, 1'b1, 5'd31, 32'h1234_5678);
    tick();
    chk("alu_rf", 136'(bus_if.mem_to_rf_bus), 136'({1'b1, 32'hAAAA_0000, 1'b0, 32'h0000_0005, 1'b1, 5'd31, 32'h1234_5678}));
    chk("alu_wb", 136'(bus_if.mem_to_wb_bus), {1'b1, 32'hAAAA_0000, 1'b0, 32'h0000_0005, 32'h300, 1'b1, 5'd31, 32'h1234_5678});
    chk("alu_exc", 136'(bus_if.except_valid), 136'h0);

    // reset while stalled
    bus_if.stall = 6'b011000;
    rst = 1'b1;
    tick();
    chk_all_zero("rst_stall");
    rst = 1'b0;
    tick();
    chk_all_zero("post_rst_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
